// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port owner: zero-clear walk, then
// fixed-priority writeback arbitration with starvation protection for req1.
module regfile_wb_arbiter #(
  parameter bit INIT_ENABLE  = 1'b1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [4:0]  req0_rd,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_rd,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        regwrite,
  output logic [4:0]  rd,
  output logic [31:0] writedata,
  output logic        init_done
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  localparam state_t RESET_STATE = INIT_ENABLE ? ST_INIT : ST_RUN;

  state_t         state, state_next;
  logic [4:0]     k;
  logic [CW-1:0]  starve_cnt;
  logic           grant0, grant1;

  always_ff @(posedge clk) begin
    if (reset) state <= RESET_STATE;
    else       state <= state_next;
  end

  // k wraps to 0 after writing r31, which marks the end of the walk.
  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state)
      ST_INIT: if (k == 5'd0) state_next = ST_RUN;
      ST_RUN: begin
        if (!reset) begin
          grant1 = req1_valid && (!req0_valid || starve_cnt == LIMIT);
          grant0 = req0_valid && !grant1;
        end
      end
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite   <= 1'b0;
      rd         <= 5'd0;
      writedata  <= 32'd0;
      init_done  <= 1'b0;
      starve_cnt <= '0;
      k          <= 5'd1;
    end else begin
      case (state)
        ST_INIT: begin
          if (k == 5'd0) begin
            regwrite  <= 1'b0;
            init_done <= 1'b1;
          end else begin
            regwrite  <= 1'b1;
            rd        <= k;
            writedata <= 32'd0;
            k         <= k + 5'd1;
          end
        end
        ST_RUN: begin
          init_done <= 1'b1;
          regwrite  <= 1'b0;
          // r0 requests complete the handshake but never raise the write enable.
          if (grant0) begin
            regwrite  <= (req0_rd != 5'd0);
            rd        <= req0_rd;
            writedata <= req0_data;
          end else if (grant1) begin
            regwrite  <= (req1_rd != 5'd0);
            rd        <= req1_rd;
            writedata <= req1_data;
          end
          if (grant1 || !req1_valid)   starve_cnt <= '0;
          else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + CW'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]  req0_rd, req1_rd, rd;
  logic [31:0] req0_data, req1_data, writedata;
  logic        regwrite, init_done;

  logic        b_reset;
  logic        b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
  logic [4:0]  b_req0_rd, b_req1_rd, b_rd;
  logic [31:0] b_req0_data, b_req1_data, b_writedata;
  logic        b_regwrite, b_init_done;

  logic [31:0] rf [32];
  logic        r0_hit;
  logic        g1;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.INIT_ENABLE(1'b1), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .regwrite(regwrite), .rd(rd), .writedata(writedata), .init_done(init_done)
  );

  regfile_wb_arbiter #(.INIT_ENABLE(1'b0), .STARVE_LIMIT(4)) dut_noinit (
    .clk(clk), .reset(b_reset),
    .req0_valid(b_req0_valid), .req0_rd(b_req0_rd), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_rd(b_req1_rd), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
    .regwrite(b_regwrite), .rd(b_rd), .writedata(b_writedata), .init_done(b_init_done)
  );

  // Register file behind the write port.
  always @(posedge clk) begin
    if (regwrite) rf[rd] <= writedata;
    if (reset) r0_hit <= 1'b0;
    else if (regwrite && rd == 5'd0) r0_hit <= 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic walk(input int upto);
    for (int e = 1; e <= upto; e++) begin
      @(posedge clk); #1;
      if (e <= 31) begin
        check("walk_ctl", {regwrite, rd, init_done, req0_ready, req1_ready},
              {1'b1, e[4:0], 1'b0, 1'b0, 1'b0});
        check("walk_data", writedata, 32'd0);
        if (e == 31) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end else begin
        check("walk_end", {regwrite, rd, init_done, req0_ready, req1_ready},
              {1'b0, 5'd31, 1'b1, 1'b0, 1'b0});
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check(tag, {regwrite, rd, writedata, init_done, req0_ready, req1_ready}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; b_reset = 1'b1;
    req0_valid = 1'b1; req0_rd = 5'd2; req0_data = 32'h1111_1111;
    req1_valid = 1'b1; req1_rd = 5'd4; req1_data = 32'h2222_2222;
    b_req0_valid = 1'b0; b_req0_rd = 5'd0; b_req0_data = 32'd0;
    b_req1_valid = 1'b0; b_req1_rd = 5'd0; b_req1_data = 32'd0;

    repeat (2) @(posedge clk);
    #1 check_reset_vals("reset_state");
    reset = 1'b0;
    walk(32);
    check("rf_r31_cleared", rf[31], 32'd0);
    check("rf_r1_cleared", rf[1], 32'd0);

    req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hDEAD_BEEF;
    #1 check("single_rdy", {req0_ready, req1_ready}, {1'b1, 1'b0});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check("single_wr", {regwrite, rd, writedata}, {1'b1, 5'd5, 32'hDEAD_BEEF});
    @(posedge clk); #1;
    check("idle_hold", {regwrite, rd, writedata}, {1'b0, 5'd5, 32'hDEAD_BEEF});
    check("rf_r5", rf[5], 32'hDEAD_BEEF);

    req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h0000_00A0;
    req1_valid = 1'b1; req1_rd = 5'd7; req1_data = 32'h0000_00B1;
    for (int i = 0; i < 10; i++) begin
      g1 = (i % 5 == 4);
      #1 check("cont_rdy", {req0_ready, req1_ready}, {!g1, g1});
      @(posedge clk); #1;
      check("cont_wr", {regwrite, rd, writedata},
            g1 ? {1'b1, 5'd7, 32'h0000_00B1} : {1'b1, 5'd3, 32'h0000_00A0});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'h0000_1234;
    #1 check("r0_rdy", {req0_ready, req1_ready}, {1'b0, 1'b1});
    @(posedge clk); #1;
    req1_valid = 1'b0;
    check("r0_wr", {regwrite, rd, writedata}, {1'b0, 5'd0, 32'h0000_1234});
    @(posedge clk); #1;
    check("r0_untouched", r0_hit, 1'b0);

    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("run_reset");
    reset = 1'b0;
    walk(17);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("midinit_reset");
    reset = 1'b0;
    walk(32);

    b_req0_valid = 1'b1; b_req0_rd = 5'd9; b_req0_data = 32'h5555_5555;
    #1 check("noinit_rdy_in_reset", b_req0_ready, 1'b0);
    b_reset = 1'b0;
    #1 check("noinit_rdy", {b_req0_ready, b_req1_ready, b_init_done}, {1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    b_req0_valid = 1'b0;
    check("noinit_wr", {b_regwrite, b_rd, b_writedata, b_init_done},
          {1'b1, 5'd9, 32'h5555_5555, 1'b1});
    @(posedge clk); #1;
    check("noinit_no_walk", {b_regwrite, b_init_done}, {1'b0, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
